// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one request/grant/response bus transaction per
// access, pipeline stall while outstanding, aligned and extended load results.
module load_store_unit (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        memread_i,
    input  logic        memwrite_i,
    input  logic [2:0]  width_select_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] store_data_i,
    input  logic [4:0]  rd_addr_i,
    output logic        stall_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_gnt_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        load_valid_o,
    output logic [31:0] load_data_o,
    output logic [4:0]  load_rd_o,
    output logic        store_done_o,
    output logic        misaligned_o,
    output logic [31:0] misaligned_addr_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic        access_s;
    logic        misaligned_s;
    logic        is_load_r;
    logic [2:0]  width_r;
    logic [1:0]  lane_r;
    logic [4:0]  rd_r;
    logic        req_r;
    logic        we_r;
    logic [31:0] bus_addr_r;
    logic [3:0]  be_r;
    logic [31:0] wdata_r;
    logic        load_valid_r;
    logic [31:0] load_data_r;
    logic [4:0]  load_rd_r;
    logic        store_done_r;
    logic        misaligned_r;
    logic [31:0] misaligned_addr_r;

    // Loads and stores decode the width code differently; bytes never fault.
    function automatic logic is_misaligned(input logic is_load, input logic [2:0] width,
                                           input logic [1:0] lane);
        logic half;
        logic word;
        half = 1'b0;
        word = 1'b0;
        if (is_load) begin
            case (width)
                3'b000, 3'b011: begin half = 1'b0; word = 1'b0; end
                3'b001, 3'b100: begin half = 1'b1; word = 1'b0; end
                default:        begin half = 1'b0; word = 1'b1; end
            endcase
        end else begin
            case (width)
                3'b000:  begin half = 1'b0; word = 1'b0; end
                3'b001:  begin half = 1'b1; word = 1'b0; end
                default: begin half = 1'b0; word = 1'b1; end
            endcase
        end
        return (half & lane[0]) | (word & (lane != 2'b00));
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] width, input logic [1:0] lane);
        case (width)
            3'b000:  return 4'b0001 << lane;
            3'b001:  return 4'b0011 << {lane[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_wdata(input logic [2:0] width, input logic [31:0] data);
        case (width)
            3'b000:  return {4{data[7:0]}};
            3'b001:  return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] width, input logic [1:0] lane,
                                                input logic [31:0] rdata);
        logic [31:0] shifted;
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        shifted = rdata >> {lane, 3'b000};
        byte_v  = shifted[7:0];
        half_v  = lane[1] ? rdata[31:16] : rdata[15:0];
        case (width)
            3'b000:  return {{24{byte_v[7]}}, byte_v};
            3'b001:  return {{16{half_v[15]}}, half_v};
            3'b011:  return {24'd0, byte_v};
            3'b100:  return {16'd0, half_v};
            default: return rdata;
        endcase
    endfunction

    assign access_s     = memread_i | memwrite_i;
    assign misaligned_s = is_misaligned(memread_i, width_select_i, addr_i[1:0]);

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (access_s) begin
                    state_s = misaligned_s ? ST_RESP : ST_REQ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (dmem_gnt_i) begin
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (dmem_rvalid_i) begin
                    state_s = ST_RESP;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_RESP: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Access capture, bus payload, and completion registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            is_load_r         <= 1'b0;
            width_r           <= 3'd0;
            lane_r            <= 2'd0;
            rd_r              <= 5'd0;
            req_r             <= 1'b0;
            we_r              <= 1'b0;
            bus_addr_r        <= 32'd0;
            be_r              <= 4'd0;
            wdata_r           <= 32'd0;
            load_valid_r      <= 1'b0;
            load_data_r       <= 32'd0;
            load_rd_r         <= 5'd0;
            store_done_r      <= 1'b0;
            misaligned_r      <= 1'b0;
            misaligned_addr_r <= 32'd0;
        end else begin
            // Completion flags are set only on entry to RESP, so they last one cycle.
            load_valid_r <= 1'b0;
            store_done_r <= 1'b0;
            misaligned_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (access_s) begin
                        is_load_r <= memread_i;
                        width_r   <= width_select_i;
                        lane_r    <= addr_i[1:0];
                        rd_r      <= rd_addr_i;
                        if (misaligned_s) begin
                            misaligned_r      <= 1'b1;
                            misaligned_addr_r <= addr_i;
                        end else begin
                            req_r      <= 1'b1;
                            we_r       <= ~memread_i;
                            bus_addr_r <= {addr_i[31:2], 2'b00};
                            be_r       <= memread_i ? 4'b1111 : store_be(width_select_i, addr_i[1:0]);
                            wdata_r    <= memread_i ? 32'd0 : store_wdata(width_select_i, store_data_i);
                        end
                    end
                end
                ST_REQ: begin
                    if (dmem_gnt_i) begin
                        req_r      <= 1'b0;
                        we_r       <= 1'b0;
                        bus_addr_r <= 32'd0;
                        be_r       <= 4'd0;
                        wdata_r    <= 32'd0;
                    end
                end
                ST_WAIT: begin
                    if (dmem_rvalid_i) begin
                        if (is_load_r) begin
                            load_valid_r <= 1'b1;
                            load_data_r  <= load_extend(width_r, lane_r, dmem_rdata_i);
                            load_rd_r    <= rd_r;
                        end else begin
                            store_done_r <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign stall_o = ((state_r == ST_IDLE) & access_s) | (state_r == ST_REQ) | (state_r == ST_WAIT);

    assign dmem_req_o        = req_r;
    assign dmem_we_o         = we_r;
    assign dmem_addr_o       = bus_addr_r;
    assign dmem_be_o         = be_r;
    assign dmem_wdata_o      = wdata_r;
    assign load_valid_o      = load_valid_r;
    assign load_data_o       = load_data_r;
    assign load_rd_o         = load_rd_r;
    assign store_done_o      = store_done_r;
    assign misaligned_o      = misaligned_r;
    assign misaligned_addr_o = misaligned_addr_r;

endmodule
